// File: rtl/palette_fade_sequencer_pkg.sv
//==============================================================================
// Module   : palette_pkg
// Brief    : Shared types and constants for the palette fade sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package palette_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FADE_OUT = 3'd1,
      HOLD     = 3'd2,
      SWAP     = 3'd3,
      FADE_IN  = 3'd4
   } fade_state_t;

   typedef enum logic [1:0] {
      GS_MENU  = 2'd0,
      GS_PLAY  = 2'd1,
      GS_PAUSE = 2'd2,
      GS_OVER  = 2'd3
   } game_state_t;

   localparam int                     PAL_COLOR_W   = 6;
   localparam logic [PAL_COLOR_W-1:0] PAL_MAX_INDEX = 6'h3C;

endpackage

`default_nettype wire

// File: rtl/palette_fade_sequencer_frame_tick_gen.sv
//==============================================================================
// Module   : frame_tick_gen
// Brief    : Vsync falling-edge detector and frame divider producing per-frame
//            and per-fade-step ticks; clr restarts the divider.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module frame_tick_gen
   import palette_pkg::*;
#(
   parameter int STEP_FRAMES = 4
)(
   input  logic Clk,
   input  logic Reset,
   input  logic vs,
   input  logic clr,
   output logic frame_tick,
   output logic step_tick
);

   localparam int                 c_cnt_w = $clog2(STEP_FRAMES + 1);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(STEP_FRAMES - 1);

   logic               r_vs_d;
   logic [c_cnt_w-1:0] r_frame_cnt;

   assign frame_tick = r_vs_d & ~vs;
   assign step_tick  = frame_tick & (r_frame_cnt == c_last);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_vs_d      <= 1'b1;
         r_frame_cnt <= '0;
      end else begin
         r_vs_d <= vs;
         if (clr) begin
            r_frame_cnt <= '0;
         end else if (frame_tick) begin
            r_frame_cnt <= step_tick ? '0 : r_frame_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/palette_fade_sequencer.sv
//==============================================================================
// Module   : palette_fade_sequencer
// Brief    : Fades the palette index out, commits a new game state, fades back
//            in. Optional black hold at level 0 via PALETTE_FADE_HOLD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module palette_fade_sequencer
   import palette_pkg::*;
#(
   parameter int                 COLOR_W     = PAL_COLOR_W,
   parameter int                 FADE_STEPS  = 8,
   parameter int                 STEP_FRAMES = 4,
   parameter logic [COLOR_W-1:0] MAX_INDEX   = PAL_MAX_INDEX,
   parameter int                 HOLD_FRAMES = 2
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               vs,
   input  logic [1:0]         gameState,
   input  logic [COLOR_W-1:0] baseColor,
   output logic [COLOR_W-1:0] colorValue,
   output logic [1:0]         curState,
   output logic [3:0]         level,
   output logic               fadeActive,
   output logic               fadeDone
);

   localparam int         c_shift  = $clog2(FADE_STEPS);
   localparam int         c_prod_w = COLOR_W + 4;
   localparam logic [3:0] c_full   = 4'(FADE_STEPS);

   fade_state_t        r_state, w_state_nxt;
   logic [3:0]         r_level, w_level_nxt;
   game_state_t        r_cur_state, w_cur_state_nxt;
   logic               r_fade_done, w_fade_done_nxt;
   logic [COLOR_W-1:0] r_color;
   logic               w_frame_tick;
   logic               w_step_tick;
   logic               w_clr;

   logic [c_prod_w-1:0] w_prod;
   logic [c_prod_w-1:0] w_idx;
   logic [COLOR_W-1:0]  w_sat;

   frame_tick_gen #(
      .STEP_FRAMES (STEP_FRAMES)
   ) u_frame_tick_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .vs         (vs),
      .clr        (w_clr),
      .frame_tick (w_frame_tick),
      .step_tick  (w_step_tick)
   );

`ifdef PALETTE_FADE_HOLD_EN
   localparam int c_hold_w = $clog2(HOLD_FRAMES + 1);

   logic [c_hold_w-1:0] r_hold_cnt;
   logic                w_hold_done;

   assign w_hold_done = (r_state == HOLD) && w_frame_tick &&
                        (r_hold_cnt == c_hold_w'(HOLD_FRAMES - 1));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_hold_cnt <= '0;
      end else if (r_state != HOLD) begin
         r_hold_cnt <= '0;
      end else if (w_frame_tick) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end
`else
   // Frame ticks are only consumed by the hold counter.
   localparam int c_unused_hold_frames = HOLD_FRAMES;
   logic          w_unused_frame_tick;
   assign w_unused_frame_tick = w_frame_tick;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_level     <= c_full;
         r_cur_state <= GS_MENU;
         r_fade_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_level     <= w_level_nxt;
         r_cur_state <= w_cur_state_nxt;
         r_fade_done <= w_fade_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_level_nxt     = r_level;
      w_cur_state_nxt = r_cur_state;
      w_fade_done_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (gameState != r_cur_state) begin
               w_state_nxt = FADE_OUT;
            end
         end
         FADE_OUT: begin
            // Level 0 is held for one cycle so black is visible before the commit.
            if (r_level == 4'd0) begin
`ifdef PALETTE_FADE_HOLD_EN
               w_state_nxt = HOLD;
`else
               w_state_nxt = SWAP;
`endif
            end else if (w_step_tick) begin
               w_level_nxt = r_level - 4'd1;
            end
         end
         HOLD: begin
`ifdef PALETTE_FADE_HOLD_EN
            if (w_hold_done) begin
               w_state_nxt = SWAP;
            end
`else
            w_state_nxt = SWAP;
`endif
         end
         SWAP: begin
            w_cur_state_nxt = game_state_t'(gameState);
            w_state_nxt     = FADE_IN;
         end
         FADE_IN: begin
            if (r_level == c_full) begin
               w_state_nxt     = IDLE;
               w_fade_done_nxt = 1'b1;
            end else if (w_step_tick) begin
               w_level_nxt = r_level + 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Every transition restarts frame counting for the next phase.
   assign w_clr = (w_state_nxt != r_state);

   assign w_prod = c_prod_w'(baseColor) * c_prod_w'(r_level);
   assign w_idx  = w_prod >> c_shift;
   assign w_sat  = (w_idx > c_prod_w'(MAX_INDEX)) ? MAX_INDEX : w_idx[COLOR_W-1:0];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_color <= '0;
      end else begin
         r_color <= (r_level == 4'd0) ? '0 : w_sat;
      end
   end

   assign colorValue = r_color;
   assign curState   = r_cur_state;
   assign level      = r_level;
   assign fadeActive = (r_state != IDLE);
   assign fadeDone   = r_fade_done;

endmodule

`default_nettype wire

// File: tb/tb_palette_fade_sequencer.sv
//==============================================================================
// Module   : tb_palette_fade_sequencer
// Brief    : Self-checking bench for palette_fade_sequencer (scoreboarded
//            level steps and colour outputs); honours PALETTE_FADE_HOLD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_palette_fade_sequencer;
   import palette_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       vs;
   logic [1:0] gameState;
   logic [5:0] baseColor;
   logic [5:0] colorValue;
   logic [1:0] curState;
   logic [3:0] level;
   logic       fadeActive;
   logic       fadeDone;

   int total = 0;
   int bad   = 0;
   int ftick = 0;

   logic [3:0] exp_lvl_q[$];
   logic [5:0] exp_col_q[$];

   palette_fade_sequencer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .vs         (vs),
      .gameState  (gameState),
      .baseColor  (baseColor),
      .colorValue (colorValue),
      .curState   (curState),
      .level      (level),
      .fadeActive (fadeActive),
      .fadeDone   (fadeDone)
   );

   always #10 Clk = ~Clk;

   // One vsync falling edge every 8 clocks.
   initial begin : vs_gen
      vs = 1'b1;
      forever begin
         repeat (6) @(negedge Clk);
         vs = 1'b0;
         ftick++;
         repeat (2) @(negedge Clk);
         vs = 1'b1;
      end
   end

   function automatic logic [5:0] col_model(input logic [5:0] b, input logic [3:0] l);
      int p;
      p = (int'(b) * int'(l)) / 8;
      if (l == 4'd0) return 6'd0;
      if (p > 60) return 6'h3C;
      return p[5:0];
   endfunction

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic push_fade();
      for (int i = 7; i >= 0; i--) exp_lvl_q.push_back(4'(i));
      for (int i = 1; i <= 8; i++) exp_lvl_q.push_back(4'(i));
   endtask

   // Monitors one full fade: pops expected levels as they appear and checks
   // the colour one cycle later; optional gameState changes on given levels.
   task automatic watch_fade(input int budget,
                             input int out_lvl, input logic [1:0] out_val,
                             input int in_lvl,  input logic [1:0] in_val,
                             output int n_done, output int n_swaps,
                             output int z_cycles, output int z_ticks);
      logic [3:0] prev_lv;
      logic [1:0] prev_cs;
      logic [3:0] el;
      logic [5:0] ec;
      int         last_tick;
      int         zero_cyc;
      int         zero_tick;
      bit         have_last;
      bit         swapped;
      bit         finished;
      prev_lv   = level;
      prev_cs   = curState;
      n_done    = 0;
      n_swaps   = 0;
      z_cycles  = -1;
      z_ticks   = -1;
      last_tick = 0;
      zero_cyc  = 0;
      zero_tick = 0;
      have_last = 0;
      swapped   = 0;
      finished  = 0;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         tick();
         if (exp_col_q.size() > 0) begin
            ec = exp_col_q.pop_front();
            total++;
            if (colorValue !== ec) begin
               bad++;
               $display("FAIL fade_colour: colorValue=%0h expected=%0h", colorValue, ec);
            end
         end
         if (level !== prev_lv) begin
            total++;
            if (exp_lvl_q.size() == 0) begin
               bad++;
               $display("FAIL fade_level_extra: level=%0d expected no change", level);
            end else begin
               el = exp_lvl_q.pop_front();
               if (level !== el) begin
                  bad++;
                  $display("FAIL fade_level: level=%0d expected=%0d", level, el);
               end
               exp_col_q.push_back(col_model(baseColor, el));
               if (have_last) begin
                  total++;
                  if (ftick - last_tick != 4) begin
                     bad++;
                     $display("FAIL step_interval: frames=%0d expected=4", ftick - last_tick);
                  end
               end
               have_last = 1;
               last_tick = ftick;
               if (el == 4'd0) begin
                  zero_cyc  = cyc;
                  zero_tick = ftick;
               end
               if (!swapped && out_lvl == int'(el)) gameState = out_val;
               if (swapped && in_lvl == int'(el)) gameState = in_val;
            end
            prev_lv = level;
         end
         if (curState !== prev_cs) begin
            n_swaps++;
            swapped   = 1;
            have_last = 0;
            z_cycles  = cyc - zero_cyc;
            z_ticks   = ftick - zero_tick;
            prev_cs   = curState;
         end
         if (fadeDone === 1'b1) begin
            n_done++;
            total++;
            if (fadeActive !== 1'b0) begin
               bad++;
               $display("FAIL done_in_idle: fadeActive=%0b expected=0", fadeActive);
            end
         end
         if (n_done > 0 && exp_lvl_q.size() == 0) finished = 1;
      end
      if (!finished) begin
         total++;
         bad++;
         $display("FAIL fade_timeout: levels_left=%0d expected=0 done=%0d", exp_lvl_q.size(), n_done);
      end
      exp_lvl_q.delete();
      exp_col_q.delete();
   endtask

   task automatic test_reset();
      Reset     = 1'b0;
      gameState = 2'd0;
      baseColor = 6'h20;
      repeat (3) tick();
      total += 5;
      if (colorValue !== 6'h00) begin bad++; $display("FAIL rst_color: got %0h want 0", colorValue); end
      if (curState !== 2'd0)    begin bad++; $display("FAIL rst_cur: got %0d want 0", curState); end
      if (level !== 4'd8)       begin bad++; $display("FAIL rst_level: got %0d want 8", level); end
      if (fadeActive !== 1'b0)  begin bad++; $display("FAIL rst_active: got %0b want 0", fadeActive); end
      if (fadeDone !== 1'b0)    begin bad++; $display("FAIL rst_done: got %0b want 0", fadeDone); end
      Reset = 1'b1;
      repeat (2) tick();
      total += 3;
      if (colorValue !== 6'h20) begin bad++; $display("FAIL idle_color: got %0h want 20", colorValue); end
      if (fadeActive !== 1'b0)  begin bad++; $display("FAIL idle_active: got %0b want 0", fadeActive); end
      if (curState !== 2'd0)    begin bad++; $display("FAIL idle_cur: got %0d want 0", curState); end
   endtask

   task automatic test_colour_idle();
      logic [5:0] tbl[8];
      logic [5:0] e;
      tbl = '{6'h3F, 6'h3C, 6'h3D, 6'h3B, 6'h00, 6'h01, 6'h2A, 6'h15};
      for (int i = 0; i < 12; i++) begin
         baseColor = (i < 8) ? tbl[i] : 6'($urandom_range(0, 63));
         exp_col_q.push_back(col_model(baseColor, 4'd8));
         tick();
         e = exp_col_q.pop_front();
         total++;
         if (colorValue !== e) begin
            bad++;
            $display("FAIL idle_sat: base=%0h colorValue=%0h expected=%0h", baseColor, colorValue, e);
         end
      end
   endtask

   task automatic test_fade_basic();
      int nd, ns, zc, zt;
      baseColor = 6'h20;
      push_fade();
      gameState = 2'd1;
      tick();
      total++;
      if (fadeActive !== 1'b1) begin bad++; $display("FAIL basic_start: fadeActive=%0b want 1", fadeActive); end
      watch_fade(2000, -1, 2'd0, -1, 2'd0, nd, ns, zc, zt);
      total += 3;
      if (nd != 1)           begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", nd); end
      if (ns != 1)           begin bad++; $display("FAIL basic_swaps: got %0d want 1", ns); end
      if (curState !== 2'd1) begin bad++; $display("FAIL basic_cur: got %0d want 1", curState); end
      total++;
`ifdef PALETTE_FADE_HOLD_EN
      if (zt < 2 || zt > 3 || zc <= 2) begin
         bad++;
         $display("FAIL hold_time: ticks=%0d cycles=%0d expected 2..3 ticks", zt, zc);
      end
`else
      if (zc != 2) begin
         bad++;
         $display("FAIL swap_time: cycles=%0d expected=2", zc);
      end
`endif
      tick();
      total += 2;
      if (fadeDone !== 1'b0)   begin bad++; $display("FAIL basic_done_pulse: got %0b want 0", fadeDone); end
      if (fadeActive !== 1'b0) begin bad++; $display("FAIL basic_idle: got %0b want 0", fadeActive); end
   endtask

   task automatic test_multi_change();
      int nd, ns, zc, zt;
      baseColor = 6'h3F;
      push_fade();
      gameState = 2'd2;
      tick();
      total++;
      if (fadeActive !== 1'b1) begin bad++; $display("FAIL multi_start: fadeActive=%0b want 1", fadeActive); end
      watch_fade(2000, 5, 2'd3, 3, 2'd0, nd, ns, zc, zt);
      total += 3;
      if (ns != 1)           begin bad++; $display("FAIL multi_swaps: got %0d want 1", ns); end
      if (curState !== 2'd3) begin bad++; $display("FAIL multi_cur: got %0d want 3", curState); end
      if (nd != 1)           begin bad++; $display("FAIL multi_done_cnt: got %0d want 1", nd); end
      tick();
      total += 2;
      if (fadeActive !== 1'b1) begin bad++; $display("FAIL refade_start: fadeActive=%0b want 1", fadeActive); end
      if (level !== 4'd8)      begin bad++; $display("FAIL refade_level: got %0d want 8", level); end
      push_fade();
      watch_fade(2000, -1, 2'd0, -1, 2'd0, nd, ns, zc, zt);
      total += 2;
      if (ns != 1)           begin bad++; $display("FAIL refade_swaps: got %0d want 1", ns); end
      if (curState !== 2'd0) begin bad++; $display("FAIL refade_cur: got %0d want 0", curState); end
   endtask

   task automatic test_async_reset();
      bit hit;
      baseColor = 6'h20;
      gameState = 2'd2;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         tick();
         if (level === 4'd3) hit = 1;
      end
      total++;
      if (!hit) begin bad++; $display("FAIL areset_reach: level=%0d want 3", level); end
      #3;
      Reset = 1'b0;
      #1;
      total += 5;
      if (colorValue !== 6'h00) begin bad++; $display("FAIL areset_color: got %0h want 0", colorValue); end
      if (level !== 4'd8)       begin bad++; $display("FAIL areset_level: got %0d want 8", level); end
      if (curState !== 2'd0)    begin bad++; $display("FAIL areset_cur: got %0d want 0", curState); end
      if (fadeActive !== 1'b0)  begin bad++; $display("FAIL areset_active: got %0b want 0", fadeActive); end
      if (fadeDone !== 1'b0)    begin bad++; $display("FAIL areset_done: got %0b want 0", fadeDone); end
      gameState = 2'd0;
      repeat (2) tick();
      Reset = 1'b1;
      repeat (4) tick();
      total += 3;
      if (fadeActive !== 1'b0)  begin bad++; $display("FAIL post_rst_active: got %0b want 0", fadeActive); end
      if (level !== 4'd8)       begin bad++; $display("FAIL post_rst_level: got %0d want 8", level); end
      if (colorValue !== 6'h20) begin bad++; $display("FAIL post_rst_color: got %0h want 20", colorValue); end
   endtask

   initial begin : main
      test_reset();
      test_colour_idle();
      test_fade_basic();
      test_multi_change();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
